multicycle_ctrl_fsm: RTL



---
 rtl/rv_ctrl_pkg.sv | 63 ++++++
 rtl/ctrl_opcode_decode.sv | 47 ++++
 rtl/multicycle_ctrl_fsm.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcodes,
// immediate-type codes, FSM states, instruction classes and mux codes.
package rv_ctrl_pkg;

    // Major opcodes (IR[6:0]) understood by the core
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Immediate-generator format select, shared with the immediate path
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // Next-PC source select
    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SRC_IMM   = 2'd1;
    localparam logic [1:0] PC_SRC_JALR  = 2'd2;

    // Register-file write-back source select
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;
    localparam logic [1:0] WB_SEL_IMM = 2'd3;

    // Reason the core stopped in TRAP
    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } ctrl_state_e;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_SYSTEM,
        CLS_ILLEGAL
    } instr_class_e;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode classifier: maps IR[6:0] to an instruction class,
// the immediate format the immediate generator must use, and a legal flag.
module ctrl_opcode_decode
    import rv_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_e op_class,
    output logic [2:0]   imm_type,
    output logic         legal
);

    // Unknown opcodes fall out as illegal with the I-format default
    always_comb begin
        op_class = CLS_ILLEGAL;
        imm_type = IMM_I;
        legal    = 1'b1;
        case (opcode)
            OP_R:      op_class = CLS_R;
            OP_I_ALU:  op_class = CLS_I_ALU;
            OP_LOAD:   op_class = CLS_LOAD;
            OP_STORE: begin
                op_class = CLS_STORE;
                imm_type = IMM_S;
            end
            OP_BRANCH: begin
                op_class = CLS_BRANCH;
                imm_type = IMM_B;
            end
            OP_LUI: begin
                op_class = CLS_LUI;
                imm_type = IMM_U;
            end
            OP_AUIPC: begin
                op_class = CLS_AUIPC;
                imm_type = IMM_U;
            end
            OP_JAL: begin
                op_class = CLS_JAL;
                imm_type = IMM_J;
            end
            OP_JALR:   op_class = CLS_JALR;
            OP_SYSTEM: op_class = CLS_SYSTEM;
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core. Walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB, waits on the memory handshake with a
// bounded wait counter, and parks in a sticky TRAP state on illegal opcodes
// or memory timeouts. MEM_TIMEOUT must lie in 1..255 (8-bit wait counter).
module multicycle_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [2:0] imm_type,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       instr_retired,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [2:0] state_o
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

    ctrl_state_e  state;
    ctrl_state_e  next_state;
    logic [7:0]   wait_cnt;
    logic [1:0]   trap_cause_q;
    logic [1:0]   next_cause;
    logic         waiting;
    instr_class_e op_class;
    logic [2:0]   dec_imm_type;
    logic         op_legal;

    ctrl_opcode_decode u_decode (
        .opcode   (opcode),
        .op_class (op_class),
        .imm_type (dec_imm_type),
        .legal    (op_legal)
    );

    // State register, wait counter (restarts on every state change) and trap cause latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_FETCH;
            wait_cnt     <= 8'd0;
            trap_cause_q <= TRAP_NONE;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                wait_cnt <= 8'd0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if ((next_state == ST_TRAP) && (state != ST_TRAP)) begin
                trap_cause_q <= next_cause;
            end
        end
    end

    // Next-state and datapath controls; everything is forced quiet while reset is held
    always_comb begin
        next_state    = state;
        next_cause    = TRAP_NONE;
        waiting       = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_PLUS4;
        imm_type      = IMM_I;
        alu_a_sel     = 1'b0;
        alu_b_sel     = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = WB_SEL_ALU;
        instr_retired = 1'b0;
        trap          = 1'b0;

        case (state)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    next_state = ST_DECODE;
                end else begin
                    waiting = 1'b1;
                    if (wait_cnt == TIMEOUT_LIMIT) begin
                        next_state = ST_TRAP;
                        next_cause = TRAP_TIMEOUT;
                    end
                end
            end

            ST_DECODE: begin
                imm_type = dec_imm_type;
                if (!op_legal) begin
                    next_state = ST_TRAP;
                    next_cause = TRAP_ILLEGAL;
                end else begin
                    next_state = ST_EXEC;
                end
            end

            ST_EXEC: begin
                imm_type = dec_imm_type;
                case (op_class)
                    CLS_AUIPC, CLS_BRANCH, CLS_JAL: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                    end
                    CLS_I_ALU, CLS_LOAD, CLS_STORE, CLS_JALR, CLS_SYSTEM: begin
                        alu_b_sel = 1'b1;
                    end
                    default: ;
                endcase
                case (op_class)
                    CLS_BRANCH: begin
                        pc_write      = 1'b1;
                        pc_src        = branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
                        instr_retired = 1'b1;
                        next_state    = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: next_state = ST_MEM;
                    default:             next_state = ST_WB;
                endcase
            end

            ST_MEM: begin
                imm_type     = dec_imm_type;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (op_class == CLS_STORE);
                if (mem_ready) begin
                    if (op_class == CLS_STORE) begin
                        pc_write      = 1'b1;
                        instr_retired = 1'b1;
                        next_state    = ST_FETCH;
                    end else begin
                        next_state = ST_WB;
                    end
                end else begin
                    waiting = 1'b1;
                    if (wait_cnt == TIMEOUT_LIMIT) begin
                        next_state = ST_TRAP;
                        next_cause = TRAP_TIMEOUT;
                    end
                end
            end

            ST_WB: begin
                imm_type      = dec_imm_type;
                reg_write     = (op_class != CLS_SYSTEM);
                pc_write      = 1'b1;
                instr_retired = 1'b1;
                next_state    = ST_FETCH;
                case (op_class)
                    CLS_LOAD:          wb_sel = WB_SEL_MEM;
                    CLS_JAL, CLS_JALR: wb_sel = WB_SEL_PC4;
                    CLS_LUI:           wb_sel = WB_SEL_IMM;
                    default:           wb_sel = WB_SEL_ALU;
                endcase
                case (op_class)
                    CLS_JAL:  pc_src = PC_SRC_IMM;
                    CLS_JALR: pc_src = PC_SRC_JALR;
                    default:  pc_src = PC_SRC_PLUS4;
                endcase
            end

            ST_TRAP: begin
                trap = 1'b1;
            end

            default: next_state = ST_FETCH;
        endcase

        if (!rst_n) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            mem_addr_sel  = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_src        = PC_SRC_PLUS4;
            imm_type      = IMM_I;
            alu_a_sel     = 1'b0;
            alu_b_sel     = 1'b0;
            reg_write     = 1'b0;
            wb_sel        = WB_SEL_ALU;
            instr_retired = 1'b0;
            trap          = 1'b0;
        end
    end

    assign state_o    = state;
    assign trap_cause = trap_cause_q;

endmodule
